uart_prog_loader: RTL and testbench
===================================

// Module: uart_prog_loader
// PURPOSE
//  UART boot loader that writes program words into the instruction memory that IFetch reads.
//  It receives a framed program image over the serial rx line and drives the IMEM write port
//  one word at a time. The CPU is held in reset while loading and released once the image
//  has been written. It sits beside CPU at the board top level and shares clk/rst with it.
// PARAMETERS
//  CLKS_PER_BIT  868  clk cycles per UART bit (100 MHz / 115200); must be >= 4
//  ADDR_W        14   IMEM word-address width; max image = 2**ADDR_W words
// PORTS
//  clk         in   1       system clock, all logic on posedge
//  rst         in   1       synchronous, active-high reset
//  start       in   1       1-cycle pulse: enter load mode
//  rx          in   1       UART serial in, idle high, asynchronous to clk
//  imem_we     out  1       IMEM write strobe, 1 cycle per word
//  imem_addr   out  ADDR_W  IMEM word address (byte addr >> 2)
//  imem_wdata  out  32      IMEM write data
//  cpu_rst     out  1       hold CPU in reset; OR with rst at top level
//  busy        out  1       load in progress
//  done        out  1       sticky: image loaded OK
//  err         out  1       sticky: framing error or length overflow
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, word/byte counters 0, rx synchroniser preset to 1.
//  RX front end:
//   - rx passes through a 2-FF synchroniser.
//   - Falling edge starts a frame. At CLKS_PER_BIT/2 the line is re-sampled; high = glitch,
//     return to idle with no byte.
//   - 8 data bits are sampled LSB first, one every CLKS_PER_BIT.
//   - Stop bit sampled 1 -> 1-cycle byte_valid. Stop bit sampled 0 -> framing error.
//  Frame format: 0xA5, N[7:0], N[15:8], then N words of 4 bytes each, little-endian.
//  FSM states: IDLE, SYNC, LEN0, LEN1, DATA, DONE.
//   - IDLE: start -> SYNC, set cpu_rst=1, clear done/err/counters. rx bytes are ignored.
//   - SYNC: byte 0xA5 -> LEN0. Any other byte is discarded and the FSM stays in SYNC.
//   - LEN0: capture N[7:0] -> LEN1.
//   - LEN1: capture N[15:8].
//       N==0 -> DONE.
//       N > 2**ADDR_W -> set err, go to IDLE.
//       else -> DATA.
//   - DATA: bytes shift into imem_wdata[7:0], [15:8], [23:16], [31:24] in that order.
//       The cycle after the 4th byte_valid, imem_we=1 for exactly 1 cycle with
//       imem_addr = word index. The index then increments.
//       After word N-1 is written -> DONE.
//   - DONE: done=1, cpu_rst=0 in the same cycle. A new start pulse restarts at SYNC.
//  busy=1 in SYNC, LEN0, LEN1 and DATA.
//  start while busy: ignored.
//  Framing error in any busy state:
//   - set err, go to IDLE, discard any partial word.
//   - cpu_rst stays 1 (the CPU must not run a partial image) until the next start.
//  imem_addr/imem_wdata: hold their last values when imem_we=0. imem_addr does not wrap;
//   the overflow check guarantees index < 2**ADDR_W.
//  rst in mid-load: returns to reset state next cycle. A partial image is left in IMEM.
//  No loss at the byte/word boundary: a byte completing on the same cycle as imem_we is
//   accepted.
// TESTING
//  1 Reset, start, send A5 02 00 13 05 10 00 B3 05 B5 00 -> imem_we at addr 0 data 0x00100513,
//    then addr 1 data 0x00B505B3; done=1, cpu_rst=0, err=0.
//  2 Send 00 FF A5 01 00 then 4 bytes -> junk bytes dropped; exactly 1 write at addr 0; done=1.
//  3 A5 00 00 -> no imem_we; done=1 right after the LEN1 byte.
//  4 Stop bit forced 0 during the 3rd data byte -> err=1, FSM in IDLE, cpu_rst=1,
//    no imem_we for that word.
//  5 ADDR_W=4, header A5 11 00 (N=17) -> err=1, no writes. N=16 loads addrs 0..15, done=1.
//  6 1-bit-wide rx low glitch of CLKS_PER_BIT/4 cycles -> no byte. rst asserted mid-word ->
//    all outputs 0 the next cycle.

Source files
------------

// File: rtl/uart_prog_loader.sv
// uart_prog_loader
//   UART boot loader. Receives a framed program image on the serial line
//   (0xA5, N[7:0], N[15:8], then N little-endian 32-bit words) and writes
//   each word into IMEM. The CPU is held in reset while a load is active and
//   released once the whole image has been written.
// Ports
//   clk_i         system clock, all logic on posedge
//   rst_i         synchronous active-high reset
//   start_i       1-cycle pulse: enter load mode
//   rx_i          UART serial input, idle high, asynchronous
//   imem_we_o     IMEM write strobe, one cycle per word
//   imem_addr_o   IMEM word address
//   imem_wdata_o  IMEM write data
//   cpu_rst_o     hold CPU in reset (ORed with rst at top level)
//   busy_o        load in progress
//   done_o        sticky: image loaded OK
//   err_o         sticky: framing error or length overflow
module uart_prog_loader #(
   parameter int CLKS_PER_BIT = 868,
   parameter int ADDR_W       = 14
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              rx_i,
   output logic              imem_we_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic [31:0]       imem_wdata_o,
   output logic              cpu_rst_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
   localparam int unsigned MAX_WORDS = 32'd1 << ADDR_W;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
   typedef enum logic [2:0] {S_IDLE, S_SYNC, S_LEN0, S_LEN1, S_DATA, S_DONE} state_e;

   // ---------------- RX front end ----------------
   logic            rx_s1_q, rx_s2_q, rx_prev_q;
   rx_state_e       rx_state_q, rx_state_d;
   logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
   logic [2:0]      rx_bit_q, rx_bit_d;
   logic [7:0]      rx_shift_q, rx_shift_d;
   logic            byte_vld_q, byte_vld_d;
   logic            frm_err_q, frm_err_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_prev_q  <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         byte_vld_q <= 1'b0;
         frm_err_q  <= 1'b0;
      end else begin
         rx_s1_q    <= rx_i;
         rx_s2_q    <= rx_s1_q;
         rx_prev_q  <= rx_s2_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         byte_vld_q <= byte_vld_d;
         frm_err_q  <= frm_err_d;
      end
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      byte_vld_d = 1'b0;
      frm_err_d  = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (rx_prev_q && !rx_s2_q) begin
               rx_state_d = RX_START;
               rx_cnt_d   = '0;
            end
         end
         RX_START: begin
            // Mid start bit: a line back high means it was only a glitch.
            if (rx_cnt_q == HALF_M1) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == FULL_M1) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
               if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
               else                  rx_bit_d   = rx_bit_q + 1'b1;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         default: begin
            if (rx_cnt_q == FULL_M1) begin
               rx_cnt_d   = '0;
               rx_state_d = RX_IDLE;
               byte_vld_d = rx_s2_q;
               frm_err_d  = !rx_s2_q;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
      endcase
   end

   // ---------------- Loader FSM ----------------
   state_e            state_q, state_d;
   logic [15:0]       len_q, len_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [1:0]        bcnt_q, bcnt_d;
   logic [23:0]       wbuf_q, wbuf_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              cpu_rst_q, cpu_rst_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              busy;
   logic [15:0]       n_w;
   logic              last_word;

   assign busy      = (state_q == S_SYNC) || (state_q == S_LEN0) ||
                      (state_q == S_LEN1) || (state_q == S_DATA);
   assign n_w       = {rx_shift_q, len_q[7:0]};
   assign last_word = (({{(32-ADDR_W){1'b0}}, idx_q} + 32'd1) == {16'd0, len_q});

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         len_q     <= '0;
         idx_q     <= '0;
         bcnt_q    <= '0;
         wbuf_q    <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         cpu_rst_q <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         idx_q     <= idx_d;
         bcnt_q    <= bcnt_d;
         wbuf_q    <= wbuf_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         cpu_rst_q <= cpu_rst_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      idx_d     = idx_q;
      bcnt_d    = bcnt_q;
      wbuf_d    = wbuf_q;
      we_d      = 1'b0;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      cpu_rst_d = cpu_rst_q;
      done_d    = done_q;
      err_d     = err_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               state_d   = S_SYNC;
               cpu_rst_d = 1'b1;
               done_d    = 1'b0;
               err_d     = 1'b0;
               len_d     = '0;
               idx_d     = '0;
               bcnt_d    = '0;
            end
         end
         S_SYNC: begin
            if (byte_vld_q && rx_shift_q == 8'hA5) state_d = S_LEN0;
         end
         S_LEN0: begin
            if (byte_vld_q) begin
               len_d[7:0] = rx_shift_q;
               state_d    = S_LEN1;
            end
         end
         S_LEN1: begin
            if (byte_vld_q) begin
               len_d = n_w;
               if (n_w == 16'd0) begin
                  state_d   = S_DONE;
                  done_d    = 1'b1;
                  cpu_rst_d = 1'b0;
               end else if ({16'd0, n_w} > MAX_WORDS) begin
                  // CPU stays in reset: no valid image is present.
                  state_d = S_IDLE;
                  err_d   = 1'b1;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         default: begin
            if (byte_vld_q) begin
               case (bcnt_q)
                  2'd0: wbuf_d[7:0]   = rx_shift_q;
                  2'd1: wbuf_d[15:8]  = rx_shift_q;
                  2'd2: wbuf_d[23:16] = rx_shift_q;
                  default: begin
                     // Word buffer is separate from the output so imem_wdata_o
                     // only changes together with the write strobe.
                     wdata_d = {rx_shift_q, wbuf_q};
                     addr_d  = idx_q;
                     we_d    = 1'b1;
                     idx_d   = idx_q + 1'b1;
                     if (last_word) begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                     end
                  end
               endcase
               bcnt_d = bcnt_q + 1'b1;
            end
         end
      endcase
      // Framing error aborts the load; cpu_rst stays set so a partial image never runs.
      if (busy && frm_err_q) begin
         state_d = S_IDLE;
         err_d   = 1'b1;
         bcnt_d  = '0;
      end
   end

   assign imem_we_o    = we_q;
   assign imem_addr_o  = addr_q;
   assign imem_wdata_o = wdata_q;
   assign cpu_rst_o    = cpu_rst_q;
   assign busy_o       = busy;
   assign done_o       = done_q;
   assign err_o        = err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
module tb_uart_prog_loader;

   localparam int CPB = 8;
   localparam int AW  = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          rx;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          cpu_rst, busy, done, err;

   int checks = 0;
   int errors = 0;

   logic [AW+31:0] exp_q[$];
   logic [31:0]    img[$];

   always #5 clk = ~clk;

   uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .rx_i(rx),
      .imem_we_o(imem_we), .imem_addr_o(imem_addr), .imem_wdata_o(imem_wdata),
      .cpu_rst_o(cpu_rst), .busy_o(busy), .done_o(done), .err_o(err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Monitor: every write the DUT presents is matched against the scoreboard.
   always @(negedge clk) begin
      if (!rst && imem_we) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual_addr=%h actual_data=%h expected=none",
                     imem_addr, imem_wdata);
         end else begin
            logic [AW+31:0] e;
            e = exp_q.pop_front();
            chk("write_addr", 32'(imem_addr), 32'(e[AW+31:32]));
            chk("write_data", imem_wdata, e[31:0]);
         end
      end
   end

   task automatic send_bit(input logic b);
      rx = b;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(stop);
      send_bit(1'b1);
      send_bit(1'b1);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Reference model: a well-formed image of n words is written word by word
   // at addresses 0..n-1 unless n exceeds the IMEM depth.
   task automatic send_image(input int n, input bit start_mid);
      send_byte(8'hA5, 1'b1);
      send_byte(n[7:0], 1'b1);
      send_byte(n[15:8], 1'b1);
      if (n <= (1 << AW)) begin
         for (int w = 0; w < n; w++) exp_q.push_back({AW'(w), img[w]});
         for (int w = 0; w < n; w++) begin
            if (start_mid && w == 0) pulse_start();
            for (int k = 0; k < 4; k++) send_byte(img[w][8*k +: 8], 1'b1);
         end
      end
   endtask

   task automatic chk_status(input string tag, input logic e_done, input logic e_err,
                             input logic e_cpu);
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk({tag, "_done"}, 32'(done), 32'(e_done));
      chk({tag, "_err"}, 32'(err), 32'(e_err));
      chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(e_cpu));
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_we"}, 32'(imem_we), 32'd0);
      chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
      chk({tag, "_wdata"}, imem_wdata, 32'd0);
      chk({tag, "_flags"}, {28'd0, cpu_rst, busy, done, err}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; rx = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk_all_zero("reset");

      // Directed: two-word image from the board bring-up example.
      img = '{32'h00100513, 32'h00B505B3};
      pulse_start();
      @(negedge clk);
      chk("start_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("start_busy", 32'(busy), 32'd1);
      send_image(2, 1'b0);
      chk_status("t1", 1'b1, 1'b0, 1'b0);

      // Junk before sync byte is dropped.
      img = '{32'hDEADBEEF};
      pulse_start();
      send_byte(8'h00, 1'b1);
      send_byte(8'hFF, 1'b1);
      send_image(1, 1'b0);
      chk_status("t2", 1'b1, 1'b0, 1'b0);

      // Empty image.
      pulse_start();
      send_image(0, 1'b0);
      chk_status("t3", 1'b1, 1'b0, 1'b0);

      // Framing error on the 3rd data byte: nothing written.
      pulse_start();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      send_byte(8'h33, 1'b0);
      chk_status("t4", 1'b0, 1'b1, 1'b1);

      // Length overflow, then a full-depth image.
      pulse_start();
      send_image(17, 1'b0);
      chk_status("t5_ovf", 1'b0, 1'b1, 1'b1);
      img.delete();
      for (int i = 0; i < 16; i++) img.push_back($urandom);
      pulse_start();
      send_image(16, 1'b0);
      chk_status("t5_full", 1'b1, 1'b0, 1'b0);

      // Short low glitch between sync and length must not create a byte.
      img = '{32'hCAFEF00D};
      pulse_start();
      send_byte(8'hA5, 1'b1);
      rx = 1'b0;
      repeat (CPB / 4) @(posedge clk);
      #1;
      rx = 1'b1;
      repeat (3 * CPB) @(posedge clk);
      #1;
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      exp_q.push_back({AW'(0), img[0]});
      for (int k = 0; k < 4; k++) send_byte(img[0][8*k +: 8], 1'b1);
      chk_status("t6_glitch", 1'b1, 1'b0, 1'b0);

      // Randomized images with junk and an ignored mid-load start pulse.
      for (int it = 0; it < 4; it++) begin
         int n;
         int nj;
         n  = $urandom_range(1, 6);
         nj = $urandom_range(0, 2);
         img.delete();
         for (int i = 0; i < n; i++) img.push_back($urandom);
         pulse_start();
         for (int j = 0; j < nj; j++) begin
            logic [7:0] jb;
            jb = 8'($urandom);
            if (jb == 8'hA5) jb = 8'h5A;
            send_byte(jb, 1'b1);
         end
         send_image(n, it[0]);
         chk_status("rand", 1'b1, 1'b0, 1'b0);
      end

      // Reset in the middle of a word.
      pulse_start();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h44, 1'b1);
      send_byte(8'h55, 1'b1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk_all_zero("midrst");
      #1;
      rst = 1'b0;
      repeat (2 * CPB) @(posedge clk);
      @(negedge clk);
      chk("midrst_nowrite", 32'(exp_q.size()), 32'd0);
      chk("midrst_we", 32'(imem_we), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
